// File: rtl/motion_update_sequencer.sv
// motion_update_sequencer
// Sweeps every cell cache once per pass. For each cell it reads the particle
// count at address 0, then each particle entry. Every read is tagged so the
// motion-update datapath knows which returning words are particles and where
// they came from. motion_update_enable stays high for the broadcast window.
module motion_update_sequencer #(
  parameter int NUM_CELLS      = 8,
  parameter int CELL_SEL_WIDTH = 3,
  parameter int ADDR_WIDTH     = 8,
  parameter int MAX_PARTICLES  = 220,
  parameter int RD_LATENCY     = 2,
  parameter int DRAIN_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_particle_num,
  output logic [CELL_SEL_WIDTH-1:0] out_cell_sel,
  output logic [ADDR_WIDTH-1:0]     out_rd_addr,
  output logic                      out_rden,
  output logic                      out_particle_valid,
  output logic [CELL_SEL_WIDTH-1:0] out_src_cell,
  output logic                      motion_update_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      count_overflow
);

  localparam int WAIT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int DRAIN_LEN = RD_LATENCY + DRAIN_CYCLES;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

  localparam logic [ADDR_WIDTH-1:0]     MAX_NUM    = ADDR_WIDTH'(MAX_PARTICLES - 1);
  localparam logic [CELL_SEL_WIDTH-1:0] LAST_CELL  = CELL_SEL_WIDTH'(NUM_CELLS - 1);
  localparam logic [WAIT_W-1:0]         WAIT_LAST  = WAIT_W'(RD_LATENCY - 1);
  localparam logic [DRAIN_W-1:0]        DRAIN_DONE = DRAIN_W'(DRAIN_LEN);

  typedef enum logic [2:0] {
    IDLE,
    RD_NUM,
    WAIT_NUM,
    ISSUE,
    NEXT_CELL,
    DRAIN,
    FLIP_WAIT,
    DONE
  } state_t;

  state_t state_reg, state_next;

  logic [CELL_SEL_WIDTH-1:0] cell_reg;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic [ADDR_WIDTH-1:0]     num_reg;
  logic [WAIT_W-1:0]         wait_cnt_reg;
  logic                      flip_cnt_reg;
  logic [DRAIN_W-1:0]        drain_cnt_reg;
  logic                      overflow_reg;
  logic                      enable_reg;

  logic                      rden_c;
  logic [ADDR_WIDTH-1:0]     rd_addr_c;
  logic                      issue_fire;
  logic                      capture;
  logic                      start_accept;
  logic                      num_over;
  logic [ADDR_WIDTH-1:0]     num_clamped;

  // Tag pipe: element 0 is written by the issuing cycle, the last element
  // lines up with the cache data RD_LATENCY cycles later.
  logic                      tag_valid_reg [RD_LATENCY];
  logic [CELL_SEL_WIDTH-1:0] tag_cell_reg  [RD_LATENCY];
  logic                      tag_valid_in  [RD_LATENCY];
  logic [CELL_SEL_WIDTH-1:0] tag_cell_in   [RD_LATENCY];

  assign start_accept = (state_reg == IDLE) && start;
  assign num_over     = (in_particle_num > MAX_NUM);
  assign num_clamped  = num_over ? MAX_NUM : in_particle_num;

  // State register; an asserted reset aborts any pass in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and read-port control.
  always_comb begin
    state_next = state_reg;
    rden_c     = 1'b0;
    rd_addr_c  = '0;
    issue_fire = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RD_NUM;
      end
      RD_NUM: begin
        // Count lives at address 0, so rd_addr_c stays at its default.
        rden_c     = 1'b1;
        state_next = WAIT_NUM;
      end
      WAIT_NUM: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          capture    = 1'b1;
          state_next = (num_clamped == '0) ? NEXT_CELL : ISSUE;
        end
      end
      ISSUE: begin
        // Address stays visible while stalled so the datapath sees it hold.
        rd_addr_c = addr_reg;
        if (in_ready) begin
          rden_c     = 1'b1;
          issue_fire = 1'b1;
          if (addr_reg == num_reg) state_next = NEXT_CELL;
        end
      end
      NEXT_CELL: begin
        state_next = (cell_reg == LAST_CELL) ? DRAIN : RD_NUM;
      end
      DRAIN: begin
        if (drain_cnt_reg >= DRAIN_DONE) state_next = FLIP_WAIT;
      end
      FLIP_WAIT: begin
        if (flip_cnt_reg) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Cell, address and count registers walking the sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_reg <= '0;
      addr_reg <= '0;
      num_reg  <= '0;
    end else begin
      if (start_accept || state_reg == DONE) begin
        cell_reg <= '0;
      end else if (state_reg == NEXT_CELL && cell_reg != LAST_CELL) begin
        cell_reg <= cell_reg + 1'b1;
      end
      if (capture) begin
        num_reg  <= num_clamped;
        addr_reg <= ADDR_WIDTH'(1);
      end else if (issue_fire) begin
        addr_reg <= addr_reg + 1'b1;
      end
    end
  end

  // Cycle timers for the count wait, the flip window and the drain window.
  // The drain timer restarts on every particle issue; when the sweep ends on
  // an empty cell it restarts one cycle later so the window is measured from
  // entry into DRAIN instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg  <= '0;
      flip_cnt_reg  <= 1'b0;
      drain_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= (state_reg == WAIT_NUM && !capture) ? wait_cnt_reg + 1'b1 : '0;
      flip_cnt_reg <= (state_reg == FLIP_WAIT) ? ~flip_cnt_reg : 1'b0;
      if (issue_fire) begin
        drain_cnt_reg <= DRAIN_W'(1);
      end else if (state_reg == NEXT_CELL && num_reg == '0) begin
        drain_cnt_reg <= '0;
      end else if (drain_cnt_reg < DRAIN_DONE) begin
        drain_cnt_reg <= drain_cnt_reg + 1'b1;
      end
    end
  end

  // Sticky overflow flag and the registered broadcast enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg <= 1'b0;
      enable_reg   <= 1'b0;
    end else begin
      if (start_accept) begin
        overflow_reg <= 1'b0;
      end else if (capture && num_over) begin
        overflow_reg <= 1'b1;
      end
      if (start_accept) begin
        enable_reg <= 1'b1;
      end else if (state_reg == DRAIN && state_next == FLIP_WAIT) begin
        enable_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        // Count reads enter with a cleared particle bit.
        assign tag_valid_in[gi] = issue_fire;
        assign tag_cell_in[gi]  = cell_reg;
      end else begin : g_body
        assign tag_valid_in[gi] = tag_valid_reg[gi-1];
        assign tag_cell_in[gi]  = tag_cell_reg[gi-1];
      end
    end
  endgenerate

  // Tag shift pipe tracking the cache read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_valid_reg[i] <= 1'b0;
        tag_cell_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_valid_reg[i] <= tag_valid_in[i];
        tag_cell_reg[i]  <= tag_cell_in[i];
      end
    end
  end

  assign out_cell_sel         = cell_reg;
  assign out_rd_addr          = rd_addr_c;
  assign out_rden             = rden_c;
  assign out_particle_valid   = tag_valid_reg[RD_LATENCY-1];
  assign out_src_cell         = tag_cell_reg[RD_LATENCY-1];
  assign motion_update_enable = enable_reg;
  assign busy                 = (state_reg != IDLE) && (state_reg != DONE);
  assign done                 = (state_reg == DONE);
  assign count_overflow       = overflow_reg;

endmodule

// File: tb/tb_motion_update_sequencer.sv
// Bench for motion_update_sequencer: a cache model answers reads, a timeline
// model built from the per-cell counts predicts every output, and one compare
// process checks the DUT against it each cycle of a pass.
module tb_motion_update_sequencer;

  localparam int NC = 8, CW = 3, AW = 8, MAXP = 220, RDL = 2, DRN = 4;
  localparam int HORIZON = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start = 1'b0;
  logic          in_ready = 1'b1;
  logic [AW-1:0] in_particle_num = '0;
  logic [CW-1:0] out_cell_sel, out_src_cell;
  logic [AW-1:0] out_rd_addr;
  logic          out_rden, out_particle_valid, motion_update_enable, busy, done, count_overflow;

  motion_update_sequencer #(
    .NUM_CELLS(NC), .CELL_SEL_WIDTH(CW), .ADDR_WIDTH(AW),
    .MAX_PARTICLES(MAXP), .RD_LATENCY(RDL), .DRAIN_CYCLES(DRN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .in_particle_num(in_particle_num), .out_cell_sel(out_cell_sel),
    .out_rd_addr(out_rd_addr), .out_rden(out_rden),
    .out_particle_valid(out_particle_valid), .out_src_cell(out_src_cell),
    .motion_update_enable(motion_update_enable), .busy(busy), .done(done),
    .count_overflow(count_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Pass description and the predicted timeline (index = cycles after start).
  int cnt [NC];
  bit ready_low [HORIZON];
  bit e_rden [HORIZON], e_addr_care [HORIZON], e_valid [HORIZON];
  bit e_en [HORIZON], e_busy [HORIZON], e_done [HORIZON], e_ovf [HORIZON];
  int e_addr [HORIZON], e_csel [HORIZON], e_src [HORIZON];
  int model_done;
  bit prev_ovf = 1'b0;

  int cyc = 0;
  int t_start = 0;
  bit cmp_on = 1'b0;
  bit pass_on = 1'b0;

  int obs_valids, obs_done_cnt, obs_done_k;
  bit obs_ovf_at_done;
  int obs_src [$];
  int obs_addr [$];

  bit hist_v [8];
  int hist_cell [8], hist_addr [8];

  // Walk the pass as a timeline: per cell one count read, RDL wait cycles,
  // one issue cycle per particle unless stalled, one cell step; then drain,
  // two flip cycles and the done pulse.
  task automatic build_model();
    int t, n, a, last_issue, last_nc, flip, ovf_from;
    for (int k = 0; k < HORIZON; k++) begin
      e_rden[k] = 0; e_addr_care[k] = 0; e_valid[k] = 0; e_en[k] = 0;
      e_busy[k] = 0; e_done[k] = 0; e_addr[k] = 0; e_csel[k] = 0; e_src[k] = 0;
    end
    t = 1; last_issue = 0; last_nc = 0; ovf_from = HORIZON;
    for (int c = 0; c < NC; c++) begin
      e_rden[t] = 1; e_addr_care[t] = 1; e_addr[t] = 0; e_csel[t] = c;
      t += 1 + RDL;
      n = cnt[c];
      if (n > MAXP - 1) begin
        n = MAXP - 1;
        if (ovf_from == HORIZON) ovf_from = t;
      end
      a = 1;
      while (a <= n) begin
        e_addr_care[t] = 1; e_addr[t] = a;
        if (!ready_low[t]) begin
          e_rden[t] = 1; e_csel[t] = c;
          e_valid[t + RDL] = 1; e_src[t + RDL] = c;
          last_issue = t;
          a++;
        end
        t++;
      end
      last_nc = t;
      t++;
    end
    if (cnt[NC-1] == 0) flip = last_nc + RDL + DRN + 2;
    else                flip = last_issue + RDL + DRN + 1;
    model_done = flip + 2;
    for (int k = 0; k < HORIZON; k++) begin
      e_busy[k] = (k >= 1) && (k < model_done);
      e_en[k]   = (k >= 1) && (k < flip);
      e_ovf[k]  = (k == 0) ? prev_ovf : (k >= ovf_from);
    end
    e_done[model_done] = 1;
  endtask

  function automatic int code_of(input int q[$]);
    int r = 0;
    foreach (q[i]) r = r * 10 + q[i];
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input driver: cache read data RDL cycles after each read, plus in_ready.
  initial forever begin
    int k, p;
    @(posedge clk);
    #1;
    p = (cyc - RDL) & 7;
    if (hist_v[p])
      in_particle_num = (hist_addr[p] == 0) ? AW'(cnt[hist_cell[p]]) : AW'(hist_cell[p] * 32 + hist_addr[p]);
    else
      in_particle_num = 8'hEE;
    k = cyc - t_start;
    in_ready = !(pass_on && k >= 0 && k < HORIZON && ready_low[k]);
  end

  // Compare process: every cycle of a pass against the timeline model.
  initial forever begin
    int k;
    @(negedge clk);
    hist_v[cyc & 7] = out_rden;
    hist_cell[cyc & 7] = int'(out_cell_sel);
    hist_addr[cyc & 7] = int'(out_rd_addr);
    if (cmp_on) begin
      k = cyc - t_start;
      if (k >= 0 && k < HORIZON) begin
        check($sformatf("ctl k=%0d {rden,valid,en,busy,done,ovf}", k),
              {out_rden, out_particle_valid, motion_update_enable, busy, done, count_overflow},
              {e_rden[k], e_valid[k], e_en[k], e_busy[k], e_done[k], e_ovf[k]});
        if (e_rden[k] || e_addr_care[k]) check($sformatf("rd_addr k=%0d", k), out_rd_addr, e_addr[k]);
        if (e_rden[k]) check($sformatf("cell_sel k=%0d", k), out_cell_sel, e_csel[k]);
        if (e_valid[k]) check($sformatf("src_cell k=%0d", k), out_src_cell, e_src[k]);
        if (out_particle_valid) begin
          obs_valids++;
          obs_src.push_back(int'(out_src_cell));
        end
        if (out_rden && out_rd_addr != 0) obs_addr.push_back(int'(out_rd_addr));
        if (done) begin
          obs_done_cnt++;
          obs_done_k = k;
          obs_ovf_at_done = count_overflow;
        end
      end
    end
  end

  task automatic clear_low();
    for (int k = 0; k < HORIZON; k++) ready_low[k] = 0;
  endtask

  // One pass: optional second start at extra_k, optional reset at abort_k.
  task automatic run_pass(input string name, input int extra_k, input int abort_k);
    build_model();
    obs_valids = 0; obs_done_cnt = 0; obs_done_k = -1; obs_ovf_at_done = 0;
    obs_src.delete(); obs_addr.delete();
    pass_on = 1;
    @(posedge clk); #1;
    t_start = cyc; start = 1; cmp_on = 1;
    for (int k = 1; k <= model_done + 3; k++) begin
      @(posedge clk); #1;
      start = (k == extra_k);
      if (k == abort_k) begin
        @(negedge clk); #2;
        cmp_on = 0;
        rst = 1'b0;
        #1;
        check({name, " rst rden"}, out_rden, 0);
        check({name, " rst busy/en/done/valid/ovf"},
              {busy, motion_update_enable, done, out_particle_valid, count_overflow}, 0);
        check({name, " rst addr/cell_sel"}, {out_rd_addr, out_cell_sel}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        pass_on = 0;
        prev_ovf = 0;
        return;
      end
    end
    cmp_on = 0;
    pass_on = 0;
    prev_ovf = e_ovf[model_done];
    check({name, " done pulses"}, obs_done_cnt, 1);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rden/valid", {out_rden, out_particle_valid}, 0);
    check("reset en/busy/done", {motion_update_enable, busy, done}, 0);
    check("reset overflow", count_overflow, 0);
    check("reset addr/cells", {out_rd_addr, out_cell_sel, out_src_cell}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    cnt = '{3, 0, 1, 0, 0, 0, 0, 2};
    clear_low();
    run_pass("basic", -1, -1);
    check("basic valid count", obs_valids, 6);
    check("basic src sequence", code_of(obs_src), 277);
    check("basic addr sequence", code_of(obs_addr), 123112);
    check("basic done cycle", obs_done_k, 46);

    cnt = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_pass("empty", -1, -1);
    check("empty valid count", obs_valids, 0);
    check("empty done cycle", obs_done_k, 42);

    cnt = '{4, 0, 0, 0, 0, 0, 0, 0};
    ready_low[6] = 1; ready_low[7] = 1; ready_low[8] = 1;
    run_pass("backpressure", -1, -1);
    check("bp valid count", obs_valids, 4);
    check("bp src sequence", code_of(obs_src), 0);
    check("bp addr sequence", code_of(obs_addr), 1234);
    check("bp done cycle", obs_done_k, 49);
    clear_low();

    cnt = '{0, 250, 0, 0, 0, 0, 0, 0};
    run_pass("overflow", -1, -1);
    check("ovf valid count", obs_valids, 219);
    check("ovf last addr", obs_addr.size() > 0 ? obs_addr[$] : 0, 219);
    check("ovf flag at done", obs_ovf_at_done, 1);
    check("ovf done cycle", obs_done_k, 261);

    cnt = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_pass("ovf clear", -1, -1);
    check("ovf cleared at done", obs_ovf_at_done, 0);

    cnt = '{3, 0, 1, 0, 0, 0, 0, 2};
    run_pass("start busy", 10, -1);
    check("start busy done cycle", obs_done_k, 46);

    run_pass("abort", -1, 5);
    repeat (2) @(posedge clk);

    run_pass("after reset", -1, -1);
    check("after reset valid count", obs_valids, 6);
    check("after reset done cycle", obs_done_k, 46);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
